bcd_frame_ctrl: RTL and testbench

Frame controller and read scheduler for the BCD serial receive path. It takes the 16-bit word stream (data plus one-cycle valid) produced by the line receiver and writes each frame of WORDS words into one half of an external ping-pong frame RAM. It validates frame length against the HO frame strobe and a word-gap timeout, then publishes the completed bank. It round-robin arbitrates two readers' word requests onto the single RAM read port.

---
 rtl/bcd_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bcd_frame_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_frame_ctrl.sv
// Frame writer for the BCD receive path: frames words into a ping-pong RAM,
// validates length/gap, publishes banks and arbitrates two readers onto the read port.
module bcd_frame_ctrl #(
   parameter int WORDS = 94,
   parameter int AW    = 7,
   parameter int TOUT  = 4095
) (
   input  logic          clk,
   input  logic          RST,
   input  logic          iHO,
   input  logic [15:0]   iData,
   input  logic          iVal,
   output logic [AW:0]   oWrAddr,
   output logic [15:0]   oWrData,
   output logic          oWrEn,
   output logic          oFrmRdy,
   output logic          oFrmErr,
   output logic          oBankVal,
   input  logic          reqA,
   input  logic          reqB,
   input  logic [AW-1:0] addrA,
   input  logic [AW-1:0] addrB,
   output logic          gntA,
   output logic          gntB,
   output logic [AW:0]   oRdAddr,
   output logic          oRdEn,
   input  logic [15:0]   iRdData,
   output logic [15:0]   oRdData,
   output logic          oValA,
   output logic          oValB
);

   localparam int GW = $clog2(TOUT + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(TOUT);

   typedef enum logic [2:0] {IDLE, RECV, DONE, ERR, HOWAIT} state_t;

   state_t          r_state, w_state_next;
   logic [AW-1:0]   r_word_idx, w_idx_next;
   logic [GW-1:0]   r_gap, w_gap_next;
   logic            r_wr_bank, w_wr_bank_next;
   logic            r_rd_bank, w_rd_bank_next;
   logic            r_bank_val, w_bank_val_next;
   logic            r_wr_en, w_wr_en_next;
   logic [AW:0]     r_wr_addr, w_wr_addr_next;
   logic [15:0]     r_wr_data, w_wr_data_next;
   logic            r_frm_rdy, w_frm_rdy_next;
   logic            r_frm_err, w_frm_err_next;

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state    <= IDLE;
         r_word_idx <= '0;
         r_gap      <= '0;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_bank_val <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_frm_rdy  <= 1'b0;
         r_frm_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_word_idx <= w_idx_next;
         r_gap      <= w_gap_next;
         r_wr_bank  <= w_wr_bank_next;
         r_rd_bank  <= w_rd_bank_next;
         r_bank_val <= w_bank_val_next;
         r_wr_en    <= w_wr_en_next;
         r_wr_addr  <= w_wr_addr_next;
         r_wr_data  <= w_wr_data_next;
         r_frm_rdy  <= w_frm_rdy_next;
         r_frm_err  <= w_frm_err_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_idx_next      = r_word_idx;
      w_gap_next      = r_gap;
      w_wr_bank_next  = r_wr_bank;
      w_rd_bank_next  = r_rd_bank;
      w_bank_val_next = r_bank_val;
      w_wr_en_next    = 1'b0;
      w_wr_addr_next  = r_wr_addr;
      w_wr_data_next  = r_wr_data;
      w_frm_rdy_next  = 1'b0;
      w_frm_err_next  = 1'b0;
      case (r_state)
         IDLE: begin
            w_idx_next = '0;
            w_gap_next = '0;
            if (iHO) w_state_next = RECV;
         end
         RECV: begin
            // A word arriving wins over both short-frame and timeout aborts.
            if (iVal) begin
               w_wr_en_next   = 1'b1;
               w_wr_addr_next = {r_wr_bank, r_word_idx};
               w_wr_data_next = iData;
               w_gap_next     = '0;
               if (r_word_idx == LAST_IDX) w_state_next = DONE;
               else                        w_idx_next   = r_word_idx + AW'(1);
            end else if (!iHO) begin
               w_state_next = ERR;
            end else begin
               w_gap_next = (r_gap == GAP_MAX) ? GAP_MAX : r_gap + GW'(1);
               if (w_gap_next == GAP_MAX) w_state_next = ERR;
            end
         end
         DONE: begin
            w_frm_rdy_next  = 1'b1;
            w_rd_bank_next  = r_wr_bank;
            w_wr_bank_next  = ~r_wr_bank;
            w_bank_val_next = 1'b1;
            w_state_next    = HOWAIT;
         end
         ERR: begin
            w_frm_err_next = 1'b1;
            w_state_next   = HOWAIT;
         end
         HOWAIT: begin
            if (!iHO) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Read arbiter: index 0 is reader A, index 1 is reader B.
   logic [1:0]    w_req, w_elig, w_pick;
   logic [1:0]    r_gnt, r_p2, r_val;
   logic          r_prio_b, r_p2_oor, r_rd_en;
   logic [AW:0]   r_rd_addr;
   logic [15:0]   r_rd_data;
   logic [AW-1:0] w_pick_addr;
   logic          w_in_range;

   assign w_req = {reqB, reqA};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_elig
         assign w_elig[gi] = r_bank_val & w_req[gi] & ~r_gnt[gi];
      end
   endgenerate

   assign w_pick[0]   = w_elig[0] & (~w_elig[1] | ~r_prio_b);
   assign w_pick[1]   = w_elig[1] & ~w_pick[0];
   assign w_pick_addr = w_pick[0] ? addrA : addrB;
   assign w_in_range  = (w_pick_addr <= LAST_IDX);

   always_ff @(posedge clk) begin
      if (RST) begin
         r_gnt     <= '0;
         r_p2      <= '0;
         r_val     <= '0;
         r_prio_b  <= 1'b0;
         r_p2_oor  <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else begin
         r_gnt   <= w_pick;
         r_rd_en <= (|w_pick) & w_in_range;
         if (|w_pick) begin
            r_rd_addr <= {r_rd_bank, w_pick_addr};
            r_prio_b  <= w_pick[0];
         end
         // Out-of-range grants travel with the pipeline and return zero data.
         r_p2     <= r_gnt;
         r_p2_oor <= ~r_rd_en;
         r_val    <= r_p2;
         if (|r_p2) r_rd_data <= r_p2_oor ? 16'h0000 : iRdData;
      end
   end

   assign oWrAddr  = r_wr_addr;
   assign oWrData  = r_wr_data;
   assign oWrEn    = r_wr_en;
   assign oFrmRdy  = r_frm_rdy;
   assign oFrmErr  = r_frm_err;
   assign oBankVal = r_bank_val;
   assign gntA     = r_gnt[0];
   assign gntB     = r_gnt[1];
   assign oRdAddr  = r_rd_addr;
   assign oRdEn    = r_rd_en;
   assign oRdData  = r_rd_data;
   assign oValA    = r_val[0];
   assign oValB    = r_val[1];

endmodule

// File: tb/tb_bcd_frame_ctrl.sv
// Directed bench for bcd_frame_ctrl with a behavioural frame RAM and
// write/read scoreboards.
module tb_bcd_frame_ctrl;
   localparam int WORDS = 94;
   localparam int AW    = 7;
   localparam int TOUT  = 16;

   logic          clk = 1'b0;
   logic          RST, iHO, iVal, reqA, reqB;
   logic [15:0]   iData, iRdData;
   logic [AW-1:0] addrA, addrB;
   logic [AW:0]   oWrAddr, oRdAddr;
   logic [15:0]   oWrData, oRdData;
   logic          oWrEn, oFrmRdy, oFrmErr, oBankVal, gntA, gntB, oRdEn, oValA, oValB;

   always #5 clk = ~clk;

   bcd_frame_ctrl #(.WORDS(WORDS), .AW(AW), .TOUT(TOUT)) dut (
      .clk(clk), .RST(RST), .iHO(iHO), .iData(iData), .iVal(iVal),
      .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrEn(oWrEn),
      .oFrmRdy(oFrmRdy), .oFrmErr(oFrmErr), .oBankVal(oBankVal),
      .reqA(reqA), .reqB(reqB), .addrA(addrA), .addrB(addrB),
      .gntA(gntA), .gntB(gntB), .oRdAddr(oRdAddr), .oRdEn(oRdEn),
      .iRdData(iRdData), .oRdData(oRdData), .oValA(oValA), .oValB(oValB)
   );

   // External ping-pong frame RAM, one-cycle read latency.
   logic [15:0] ram [0:255];
   always @(posedge clk) begin
      if (oWrEn) ram[oWrAddr] <= oWrData;
      iRdData <= oRdEn ? ram[oRdAddr] : 16'hBEEF;
   end

   int n_vec = 0;
   int n_err = 0;
   int n_rdy = 0;
   int n_ferr = 0;
   logic [23:0] wr_q [$];
   logic [16:0] rd_q [$];
   logic [23:0] mon_we;
   logic [16:0] mon_re;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (oWrEn === 1'b1) begin
         chk("wr_pending", 32'(wr_q.size() != 0), 32'd1);
         if (wr_q.size() != 0) begin
            mon_we = wr_q.pop_front();
            chk("wr_word", {8'h00, oWrAddr, oWrData}, {8'h00, mon_we});
         end
      end
      if (oValA === 1'b1 || oValB === 1'b1) begin
         chk("rd_pending", 32'(rd_q.size() != 0), 32'd1);
         if (rd_q.size() != 0) begin
            mon_re = rd_q.pop_front();
            chk("rd_word", {14'h0, oValA, oValB, oRdData},
                {14'h0, ~mon_re[16], mon_re[16], mon_re[15:0]});
         end
      end
      if (oFrmRdy === 1'b1) n_rdy++;
      if (oFrmErr === 1'b1) n_ferr++;
   end

   task automatic send_frame(input logic [15:0] base, input int n, input logic bank, input bit good);
      logic [15:0] d;
      iHO = 1'b1;
      tick(1);
      for (int i = 0; i < n; i++) begin
         d = base + 16'(i);
         iVal = 1'b1;
         iData = d;
         wr_q.push_back({bank, 7'(i), d});
         tick(1);
         iVal = 1'b0;
         if (i < n - 1) tick(2);
      end
      $display("frame base=%h words=%0d bank=%0d", base, n, bank);
      if (good) begin
         @(negedge clk);
         chk("rdy_early", 32'(oFrmRdy), 32'd0);
         @(negedge clk);
         chk("rdy_pulse", 32'(oFrmRdy), 32'd1);
         chk("bank_val", 32'(oBankVal), 32'd1);
         tick(1);
         iHO = 1'b0;
         tick(2);
      end
   endtask

   task automatic read_one(input bit b, input logic [6:0] a, input logic bank, input logic [15:0] exp);
      if (b) begin reqB = 1'b1; addrB = a; end
      else   begin reqA = 1'b1; addrA = a; end
      rd_q.push_back({b, exp});
      @(posedge clk);
      @(negedge clk);
      chk("rd_gnt", 32'({gntA, gntB}), b ? 32'd1 : 32'd2);
      chk("rd_addr", 32'(oRdAddr), 32'({bank, a}));
      chk("rd_en", 32'(oRdEn), 32'(a < 7'(WORDS)));
      reqA = 1'b0;
      reqB = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rd_lat", 32'({oValA, oValB}), b ? 32'd1 : 32'd2);
      $display("read %s addr=%0d bank=%0d data=%h", b ? "B" : "A", a, bank, oRdData);
      tick(1);
   endtask

   initial begin
      RST = 1'b1; iHO = 1'b0; iVal = 1'b0; iData = '0;
      reqA = 1'b0; reqB = 1'b0; addrA = '0; addrB = '0;
      tick(3);
      chk("rst_wr", 32'({oWrAddr, oWrData, oWrEn, oFrmRdy, oFrmErr, oBankVal}), 32'd0);
      chk("rst_rd", 32'({gntA, gntB, oRdAddr, oRdEn, oRdData, oValA, oValB}), 32'd0);
      RST = 1'b0;

      // No bank published yet: a held request must not be granted.
      reqA = 1'b1; addrA = 7'd2;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("gnt_nobank", 32'({gntA, gntB}), 32'd0);
      end
      reqA = 1'b0;
      tick(1);

      send_frame(16'h0000, WORDS, 1'b0, 1'b1);
      read_one(1'b0, 7'd5, 1'b0, 16'h0005);
      send_frame(16'h1000, WORDS, 1'b1, 1'b1);
      read_one(1'b0, 7'd5, 1'b1, 16'h1005);
      send_frame(16'h2000, WORDS, 1'b0, 1'b1);

      // Short frame into bank 1, aborted by HO dropping.
      send_frame(16'h3000, 40, 1'b1, 1'b0);
      iHO = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("short_err_early", 32'(oFrmErr), 32'd0);
      @(negedge clk);
      chk("short_err", 32'(oFrmErr), 32'd1);
      tick(2);
      chk("short_rdy_cnt", 32'(n_rdy), 32'd3);
      read_one(1'b0, 7'd5, 1'b0, 16'h2005);
      send_frame(16'h4000, WORDS, 1'b1, 1'b1);
      read_one(1'b0, 7'd39, 1'b1, 16'h4027);

      // Word-gap timeout in bank 0, then ignored words until HO cycles.
      send_frame(16'h5000, 11, 1'b0, 1'b0);
      repeat (17) @(negedge clk);
      chk("gap_err_early", 32'(oFrmErr), 32'd0);
      @(negedge clk);
      chk("gap_err", 32'(oFrmErr), 32'd1);
      tick(1);
      iVal = 1'b1; iData = 16'hDEAD;
      tick(1);
      iVal = 1'b0;
      tick(2);
      iHO = 1'b0;
      tick(2);
      chk("gap_err_cnt", 32'(n_ferr), 32'd2);
      send_frame(16'h6000, WORDS, 1'b0, 1'b1);
      read_one(1'b1, 7'd10, 1'b0, 16'h600A);

      // Both readers held: alternate A,B starting with A.
      for (int k = 0; k < 8; k++)
         rd_q.push_back((k % 2 == 1) ? {1'b1, 16'h6007} : {1'b0, 16'h6003});
      reqA = 1'b1; addrA = 7'd3; reqB = 1'b1; addrB = 7'd7;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("arb_gnt", 32'({gntA, gntB}), (k % 2 == 1) ? 32'd1 : 32'd2);
         chk("arb_addr", 32'(oRdAddr), (k % 2 == 1) ? 32'd7 : 32'd3);
         if (k == 7) begin reqA = 1'b0; reqB = 1'b0; end
      end
      tick(4);
      read_one(1'b1, 7'd100, 1'b0, 16'h0000);

      // Reset in the middle of a frame with a read in flight.
      send_frame(16'h7000, 50, 1'b1, 1'b0);
      reqA = 1'b1; addrA = 7'd1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_gnt", 32'(gntA), 32'd1);
      RST = 1'b1; reqA = 1'b0; iVal = 1'b1; iData = 16'h7032;
      @(posedge clk);
      #1;
      iVal = 1'b0; iHO = 1'b0; RST = 1'b0;
      @(negedge clk);
      chk("mid_rst_wr", 32'({oWrAddr, oWrData, oWrEn, oFrmRdy, oFrmErr, oBankVal}), 32'd0);
      chk("mid_rst_rd", 32'({gntA, gntB, oRdAddr, oRdEn, oRdData, oValA, oValB}), 32'd0);
      tick(6);
      send_frame(16'h8000, WORDS, 1'b0, 1'b1);

      // Pointer back at A after reset.
      rd_q.push_back({1'b0, 16'h8002});
      rd_q.push_back({1'b1, 16'h8004});
      reqA = 1'b1; addrA = 7'd2; reqB = 1'b1; addrB = 7'd4;
      @(posedge clk);
      @(negedge clk);
      chk("rst_ptr_a", 32'({gntA, gntB}), 32'd2);
      reqA = 1'b0;
      @(negedge clk);
      chk("rst_ptr_b", 32'({gntA, gntB}), 32'd1);
      reqB = 1'b0;
      tick(5);

      chk("wr_left", 32'(wr_q.size()), 32'd0);
      chk("rd_left", 32'(rd_q.size()), 32'd0);
      chk("rdy_total", 32'(n_rdy), 32'd6);
      chk("err_total", 32'(n_ferr), 32'd2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
